// File: rtl/tx_intf_pkg.sv
// Shared definitions for the tx interface command path.
// Contents:
//   - Default AXI word addresses for the command push and status/control registers.
//   - Bit offsets and widths of the fields in a tx command word.
//   - State encoding of the command FIFO output FSM.
package tx_intf_pkg;

  localparam logic [4:0] CMD_ADDR_DEF  = 5'h17;
  localparam logic [4:0] STAT_ADDR_DEF = 5'h18;

  // Command word layout; bits [23:14] are reserved and not forwarded.
  localparam int PKT_SN_LSB  = 0;
  localparam int PKT_SN_W    = 10;
  localparam int QUEUE_LSB   = 10;
  localparam int QUEUE_W     = 2;
  localparam int PRIO_LSB    = 12;
  localparam int PRIO_W      = 2;
  localparam int RETRY_LSB   = 24;
  localparam int RETRY_W     = 4;
  localparam int CW_MAX_LSB  = 28;
  localparam int CW_MAX_W    = 4;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/tx_cmd_fifo_mem.sv
// Simple dual-port command store: one write port and one synchronous read
// port with a single cycle of read latency. No reset; contents are only
// meaningful where the owning FIFO has written them.
// Ports:
//   clk      in   clock for both ports
//   wr_en    in   write enable
//   wr_addr  in   write word address
//   wr_data  in   write data
//   rd_en    in   read enable; rd_data updates on the following edge
//   rd_addr  in   read word address
//   rd_data  out  registered read data
module tx_cmd_fifo_mem #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tx_cmd_fifo.sv
// Host-to-hardware tx command FIFO. The host pushes 32-bit command words over
// AXI-lite; the tx engine pops them in order through a valid/ready port whose
// fields are held in an output register refilled from a sync-read store.
// Optional feature macro: TX_CMD_FIFO_FLUSH_EN (write of bit0=1 to STAT_ADDR
// flushes all queued commands, including the one presented on cmd_*).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   slv_reg_wren        AXI write strobe
//   axi_awaddr_core     AXI write word address
//   axi_wdata           AXI write data
//   slv_reg_rden        AXI read strobe
//   axi_araddr_core     AXI read word address
//   cmd_status_out      {overflow, zeros, occupancy}
//   cmd_valid           command on cmd_* is valid
//   cmd_ready           tx engine accepts the command
//   cmd_pkt_sn .. cmd_cw_max  fields of the presented command word
module tx_cmd_fifo
  import tx_intf_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 6,
  parameter logic [4:0] CMD_ADDR   = CMD_ADDR_DEF,
  parameter logic [4:0] STAT_ADDR  = STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slv_reg_wren,
  input  logic [4:0]  axi_awaddr_core,
  input  logic [31:0] axi_wdata,
  input  logic        slv_reg_rden,
  input  logic [4:0]  axi_araddr_core,
  output logic [31:0] cmd_status_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_pkt_sn,
  output logic [1:0]  cmd_queue_idx,
  output logic [1:0]  cmd_linux_prio,
  output logic [3:0]  cmd_retry_limit,
  output logic [3:0]  cmd_cw_max
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  cmd_state_t            state;

  logic                  push_req;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  stat_rd;
  logic                  flush;
  logic [31:0]           rd_data;
  logic [CNT_W-1:0]      occupancy;
  logic                  unused_rd_bits;

  assign push_req = slv_reg_wren && (axi_awaddr_core == CMD_ADDR);
  // Full is taken from the registered count, so a pop in the same cycle
  // does not make room for a push.
  assign full     = (count == CNT_W'(DEPTH));
  assign push     = push_req && !full;
  assign stat_rd  = slv_reg_rden && (axi_araddr_core == STAT_ADDR);

`ifdef TX_CMD_FIFO_FLUSH_EN
  assign flush = slv_reg_wren && (axi_awaddr_core == STAT_ADDR) && axi_wdata[0];
`else
  assign flush = 1'b0;
`endif

  // A store pop refills the output register: either from idle, or right as
  // the presented command is accepted. Flush overrides any refill.
  assign pop = !flush && (count != '0) &&
               ((state == S_EMPTY) || ((state == S_VALID) && cmd_ready));

  // The command held in the output register counts as occupied.
  assign occupancy      = count + CNT_W'(state != S_EMPTY);
  assign cmd_status_out = {overflow, {(31-CNT_W){1'b0}}, occupancy};

  // Reserved command bits never reach the outputs.
  assign unused_rd_bits = ^rd_data[RETRY_LSB-1:PRIO_LSB+PRIO_W];

  tx_cmd_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (axi_wdata),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Sticky overflow; a dropped push in the same cycle as a status read
  // keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  overflow <= 1'b0;
    else if (push_req && full) overflow <= 1'b1;
    else if (stat_rd)          overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_EMPTY;
      cmd_valid       <= 1'b0;
      cmd_pkt_sn      <= '0;
      cmd_queue_idx   <= '0;
      cmd_linux_prio  <= '0;
      cmd_retry_limit <= '0;
      cmd_cw_max      <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      cmd_valid <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (count != '0) state <= S_FETCH;
        end
        S_FETCH: begin
          cmd_pkt_sn      <= rd_data[PKT_SN_LSB +: PKT_SN_W];
          cmd_queue_idx   <= rd_data[QUEUE_LSB  +: QUEUE_W];
          cmd_linux_prio  <= rd_data[PRIO_LSB   +: PRIO_W];
          cmd_retry_limit <= rd_data[RETRY_LSB  +: RETRY_W];
          cmd_cw_max      <= rd_data[CW_MAX_LSB +: CW_MAX_W];
          cmd_valid       <= 1'b1;
          state           <= S_VALID;
        end
        S_VALID: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= (count != '0) ? S_FETCH : S_EMPTY;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_cmd_fifo.sv
// Directed self-checking bench for tx_cmd_fifo (default parameters).
// Honours TX_CMD_FIFO_FLUSH_EN the same way the design does.
module tb_tx_cmd_fifo;
  import tx_intf_pkg::*;

  logic        clk;
  logic        rst;
  logic        slv_reg_wren;
  logic [4:0]  axi_awaddr_core;
  logic [31:0] axi_wdata;
  logic        slv_reg_rden;
  logic [4:0]  axi_araddr_core;
  logic [31:0] cmd_status_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_pkt_sn;
  logic [1:0]  cmd_queue_idx;
  logic [1:0]  cmd_linux_prio;
  logic [3:0]  cmd_retry_limit;
  logic [3:0]  cmd_cw_max;

  int vectors     = 0;
  int miscompares = 0;

  tx_cmd_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .slv_reg_wren    (slv_reg_wren),
    .axi_awaddr_core (axi_awaddr_core),
    .axi_wdata       (axi_wdata),
    .slv_reg_rden    (slv_reg_rden),
    .axi_araddr_core (axi_araddr_core),
    .cmd_status_out  (cmd_status_out),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_pkt_sn      (cmd_pkt_sn),
    .cmd_queue_idx   (cmd_queue_idx),
    .cmd_linux_prio  (cmd_linux_prio),
    .cmd_retry_limit (cmd_retry_limit),
    .cmd_cw_max      (cmd_cw_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
  endtask

  task automatic push_word(input logic [31:0] w);
    slv_reg_wren    = 1'b1;
    axi_awaddr_core = CMD_ADDR_DEF;
    axi_wdata       = w;
    step();
    slv_reg_wren    = 1'b0;
  endtask

  task automatic status_read();
    slv_reg_rden    = 1'b1;
    axi_araddr_core = STAT_ADDR_DEF;
    step();
    slv_reg_rden    = 1'b0;
  endtask

  // Waits (bounded) for a presented command, checks its sequence number,
  // then lets the handshake edge pass.
  task automatic pop_expect(input string tag, input logic [9:0] exp_sn);
    int n = 0;
    cmd_ready = 1'b1;
    while (!cmd_valid && n < 8) begin
      step();
      n++;
    end
    if (!cmd_valid) check_output({tag, "_timeout"}, 32'(cmd_valid), 32'd1);
    else begin
      check_output(tag, 32'(cmd_pkt_sn), 32'(exp_sn));
      step();
    end
  endtask

  initial begin
    int got;
    logic prev_valid;

    rst             = 1'b1;
    slv_reg_wren    = 1'b0;
    axi_awaddr_core = '0;
    axi_wdata       = '0;
    slv_reg_rden    = 1'b0;
    axi_araddr_core = '0;
    cmd_ready       = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check_output("rst_valid",  32'(cmd_valid), 32'd0);
    check_output("rst_status", cmd_status_out, 32'd0);
    check_output("rst_fields", 32'({cmd_cw_max, cmd_retry_limit, cmd_linux_prio,
                                    cmd_queue_idx, cmd_pkt_sn}), 32'd0);

    // 1: single command, latency and field decode
    cmd_ready = 1'b1;
    push_word(32'hA300_2C05);
    check_output("t1_occ_t1",   cmd_status_out, 32'd1);
    check_output("t1_valid_t1", 32'(cmd_valid), 32'd0);
    step();
    check_output("t1_valid_t2a", 32'(cmd_valid), 32'd0);
    step();
    check_output("t1_valid_t2", 32'(cmd_valid), 32'd1);
    check_output("t1_sn",    32'(cmd_pkt_sn),      32'h005);
    check_output("t1_queue", 32'(cmd_queue_idx),   32'd3);
    check_output("t1_prio",  32'(cmd_linux_prio),  32'd2);
    check_output("t1_retry", 32'(cmd_retry_limit), 32'd3);
    check_output("t1_cwmax", 32'(cmd_cw_max),      32'hA);
    step();
    check_output("t1_valid_after", 32'(cmd_valid), 32'd0);
    check_output("t1_occ_after",   cmd_status_out, 32'd0);

    // 2: overfill, overflow flag, read-clear, in-order drain across wrap
    cmd_ready = 1'b0;
    for (int i = 1; i <= 66; i++) push_word(32'(i));
    check_output("t2_status_full", cmd_status_out, 32'h8000_0041);
    status_read();
    check_output("t2_status_clr", cmd_status_out, 32'h0000_0041);
    for (int i = 1; i <= 65; i++) pop_expect("t2_order", 10'(i));
    check_output("t2_drained", cmd_status_out, 32'd0);

    // 3: back-to-back pushes with ready held high
    cmd_ready  = 1'b1;
    got        = 0;
    prev_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 8) begin
        slv_reg_wren    = 1'b1;
        axi_awaddr_core = CMD_ADDR_DEF;
        axi_wdata       = 32'(301 + c);
      end else begin
        slv_reg_wren = 1'b0;
      end
      step();
      if (cmd_valid) begin
        check_output("t3_order",   32'(cmd_pkt_sn), 32'(301 + got));
        check_output("t3_spacing", 32'(prev_valid), 32'd0);
        got++;
      end
      prev_valid = cmd_valid;
    end
    slv_reg_wren = 1'b0;
    check_output("t3_count", 32'(got), 32'd8);

    // 4: push at full coinciding with a pop and a status read
    cmd_ready = 1'b0;
    for (int i = 201; i <= 265; i++) push_word(32'(i));
    check_output("t4_full", cmd_status_out, 32'h0000_0041);
    cmd_ready       = 1'b1;
    slv_reg_rden    = 1'b1;
    axi_araddr_core = STAT_ADDR_DEF;
    push_word(32'd266);
    slv_reg_rden    = 1'b0;
    check_output("t4_drop", cmd_status_out, 32'h8000_0040);
    for (int i = 202; i <= 265; i++) pop_expect("t4_order", 10'(i));
    check_output("t4_drained", cmd_status_out, 32'h8000_0000);
    status_read();
    check_output("t4_clr", cmd_status_out, 32'd0);

    // 5: asynchronous reset while a command is presented
    cmd_ready = 1'b0;
    push_word(32'hF5C0_3FFF);
    step();
    step();
    check_output("t5_valid_pre", 32'(cmd_valid), 32'd1);
    rst = 1'b1;
    #2;
    check_output("t5_valid_rst",  32'(cmd_valid), 32'd0);
    check_output("t5_status_rst", cmd_status_out, 32'd0);
    check_output("t5_fields_rst", 32'({cmd_cw_max, cmd_retry_limit, cmd_linux_prio,
                                       cmd_queue_idx, cmd_pkt_sn}), 32'd0);
    step();
    rst = 1'b0;
    step();
    push_word(32'h0000_0123);
    pop_expect("t5_after", 10'h123);

    // 6: write of 1 to the status/control address
    cmd_ready = 1'b0;
    for (int i = 401; i <= 405; i++) push_word(32'(i));
    step();
    check_output("t6_occ", cmd_status_out, 32'd5);
    slv_reg_wren    = 1'b1;
    axi_awaddr_core = STAT_ADDR_DEF;
    axi_wdata       = 32'd1;
    step();
    slv_reg_wren    = 1'b0;
`ifdef TX_CMD_FIFO_FLUSH_EN
    check_output("t6_flush_valid",  32'(cmd_valid), 32'd0);
    check_output("t6_flush_status", cmd_status_out, 32'd0);
    push_word(32'd406);
    pop_expect("t6_after_flush", 10'd406);
`else
    check_output("t6_noflush_valid",  32'(cmd_valid), 32'd1);
    check_output("t6_noflush_status", cmd_status_out, 32'd5);
    for (int i = 401; i <= 405; i++) pop_expect("t6_order", 10'(i));
`endif
    check_output("t6_end", cmd_status_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
